// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receive path and the future transmit
// block.
//   DATA_BITS            : data bits per 8N1 frame
//   CLKS_PER_BIT_DEFAULT : 50 MHz system clock / 115200 baud
//   uart_rx_state_t      : receiver FSM state encoding
//   half_bit()           : offset from the start edge to the start-bit centre
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  // Rounded down, so an even bit period samples slightly before its centre.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_if
// Connection between the RX synchronizer / byte consumer and the receiver.
//   i_Rx_Sync   : synchronized serial line, idle high
//   o_Rx_DV     : one-cycle pulse, o_Rx_Byte holds a new good byte
//   o_Rx_Byte   : last good received byte, LSB first on the line
//   o_Frame_Err : one-cycle pulse, stop bit sampled low
//   o_Busy      : receiver is not idle
// Modports: slave = the receiver, master = the environment around it.
// -----------------------------------------------------------------------------
interface uart_rx_fsm_if;
  import uart_pkg::*;

  logic                 i_Rx_Sync;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Frame_Err;
  logic                 o_Busy;

  modport slave  (input  i_Rx_Sync, output o_Rx_DV, output o_Rx_Byte,
                  output o_Frame_Err, output o_Busy);
  modport master (output i_Rx_Sync, input  o_Rx_DV, input  o_Rx_Byte,
                  input  o_Frame_Err, input  o_Busy);
endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Bit-period counter shared by the UART receive and transmit sides.
//   i_Clock    : system clock, rising edge
//   i_Reset_n  : asynchronous active-low reset
//   i_Clear    : synchronous clear to 0 (wins over i_Enable)
//   i_Enable   : count up by one
//   o_Count    : current count
//   o_Terminal : count has reached CLKS_PER_BIT-1
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Clear,
  input  logic             i_Enable,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Terminal
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clear) begin
      cnt_d = '0;
    end else if (i_Enable) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Count    = cnt_q;
  assign o_Terminal = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_fsm_chk.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_chk
// Parameter and output-protocol checks for uart_rx_fsm.
//   i_Clock     : system clock
//   i_Reset_n   : asynchronous active-low reset
//   i_Rx_DV     : receiver data-valid pulse
//   i_Frame_Err : receiver framing-error pulse
// -----------------------------------------------------------------------------
module uart_rx_fsm_chk #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic i_Clock,
  input logic i_Reset_n,
  input logic i_Rx_DV,
  input logic i_Frame_Err
);

  // Below 4 clocks per bit the start-bit centre and the first data sample collide.
  if (CLKS_PER_BIT < 4) begin : g_cpb_too_small
    $error("uart_rx_fsm: CLKS_PER_BIT must be at least 4");
  end

  a_dv_err_exclusive: assert property (
    @(posedge i_Clock) disable iff (!i_Reset_n) !(i_Rx_DV && i_Frame_Err)
  );

endmodule

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// 8N1 UART byte receiver. It finds the start bit and samples the start bit at
// its centre. It then samples each data bit and the stop bit one bit period
// apart and assembles the byte LSB first. A good byte is reported with a
// one-cycle o_Rx_DV pulse and a low stop bit with a one-cycle o_Frame_Err
// pulse.
//   i_Clock   : system clock, rising edge
//   i_Reset_n : asynchronous active-low reset
//   rx_if     : uart_rx_fsm_if.slave (line in; byte, pulses and busy out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic         i_Clock,
  input  logic         i_Reset_n,
  uart_rx_fsm_if.slave rx_if
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_rx_state_t       state_q,   state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] byte_q,    byte_d;
  logic                 dv_q,      dv_d;
  logic                 ferr_q,    ferr_d;
  logic                 busy_q,    busy_d;

  logic                 cnt_clr_s;
  logic                 cnt_en_s;
  logic [CNT_W-1:0]     cnt_s;
  logic                 cnt_tc_s;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Clear    (cnt_clr_s),
    .i_Enable   (cnt_en_s),
    .o_Count    (cnt_s),
    .o_Terminal (cnt_tc_s)
  );

  // Next state, shift register, output pulses and bit-timer control.
  // The line is read only at the sample points, so noise elsewhere in a bit is ignored.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    cnt_clr_s = 1'b1;
    cnt_en_s  = 1'b0;

    case (state_q)
      IDLE: begin
        bit_idx_d = 3'd0;
        if (!rx_if.i_Rx_Sync) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_s == HALF) begin
          // A high start bit at its centre is treated as a glitch and dropped silently.
          if (!rx_if.i_Rx_Sync) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end
      end

      DATA: begin
        if (cnt_tc_s) begin
          shift_d[bit_idx_q] = rx_if.i_Rx_Sync;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end
      end

      STOP: begin
        if (cnt_tc_s) begin
          if (rx_if.i_Rx_Sync) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end
      end

      WAIT_IDLE: begin
        // Wait for the line to return high so that a break or a held-low line cannot start a frame.
        if (rx_if.i_Rx_Sync) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy is registered from the next state so that it lines up with state_q.
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.o_Rx_DV     = dv_q;
  assign rx_if.o_Rx_Byte   = byte_q;
  assign rx_if.o_Frame_Err = ferr_q;
  assign rx_if.o_Busy      = busy_q;

  uart_rx_fsm_chk #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_chk (
    .i_Clock     (i_Clock),
    .i_Reset_n   (i_Reset_n),
    .i_Rx_DV     (rx_if.o_Rx_DV),
    .i_Frame_Err (rx_if.o_Frame_Err)
  );

endmodule
